// File: rtl/lockin_sweep_ctrl.sv
// Frequency sweep sequencer for a lock-in amplifier: steps the reference tuning word,
// discards settling results, averages magnitudes per point and tracks the peak.
module lockin_sweep_ctrl #(
    parameter int unsigned FTW_WIDTH      = 32,
    parameter int unsigned MAG_WIDTH      = 24,
    parameter int unsigned AVG_LOG2       = 2,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [FTW_WIDTH-1:0] start_ftw,
    input  logic [FTW_WIDTH-1:0] step_ftw,
    input  logic [11:0]          num_points,
    input  logic [7:0]           settle_results,
    input  logic [MAG_WIDTH-1:0] lia_magnitude,
    input  logic                 lia_result_valid,
    input  logic                 lia_locked,
    output logic [FTW_WIDTH-1:0] ref_freq_tuning,
    output logic                 point_valid,
    output logic [11:0]          point_index,
    output logic [MAG_WIDTH-1:0] point_mag,
    output logic                 point_locked,
    output logic [FTW_WIDTH-1:0] peak_ftw,
    output logic [MAG_WIDTH-1:0] peak_mag,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err
);

    localparam int unsigned SUM_WIDTH = MAG_WIDTH + AVG_LOG2;
    localparam int unsigned AVG_COUNT = 1 << AVG_LOG2;
    localparam int unsigned ACC_WIDTH = AVG_LOG2 + 1;
    localparam int unsigned WD_WIDTH  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PROGRAM = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_ACQUIRE = 3'd3;
    localparam logic [2:0] S_RECORD  = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]           state, state_d;
    logic [FTW_WIDTH-1:0] cfg_step, cfg_step_d;
    logic [11:0]          cfg_points, cfg_points_d;
    logic [7:0]           cfg_settle, cfg_settle_d;
    logic [FTW_WIDTH-1:0] cur_ftw, cur_ftw_d;
    logic [11:0]          index, index_d;
    logic [7:0]           disc_cnt, disc_cnt_d;
    logic [ACC_WIDTH-1:0] acc_cnt, acc_cnt_d;
    logic [SUM_WIDTH-1:0] sum, sum_d;
    logic [WD_WIDTH-1:0]  wd_cnt, wd_cnt_d;

    logic [FTW_WIDTH-1:0] ref_freq_tuning_d;
    logic                 point_valid_d;
    logic [11:0]          point_index_d;
    logic [MAG_WIDTH-1:0] point_mag_d;
    logic                 point_locked_d;
    logic [FTW_WIDTH-1:0] peak_ftw_d;
    logic [MAG_WIDTH-1:0] peak_mag_d;
    logic                 busy_d;
    logic                 done_d;
    logic                 timeout_err_d;

    logic [MAG_WIDTH-1:0] avg_c;
    logic                 wd_expired_c;

    assign avg_c        = MAG_WIDTH'(sum >> AVG_LOG2);
    assign wd_expired_c = (wd_cnt == WD_WIDTH'(TIMEOUT_CYCLES - 1));

    // State register and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            cfg_step        <= '0;
            cfg_points      <= '0;
            cfg_settle      <= '0;
            cur_ftw         <= '0;
            index           <= '0;
            disc_cnt        <= '0;
            acc_cnt         <= '0;
            sum             <= '0;
            wd_cnt          <= '0;
            ref_freq_tuning <= '0;
            point_valid     <= 1'b0;
            point_index     <= '0;
            point_mag       <= '0;
            point_locked    <= 1'b0;
            peak_ftw        <= '0;
            peak_mag        <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            timeout_err     <= 1'b0;
        end else begin
            state           <= state_d;
            cfg_step        <= cfg_step_d;
            cfg_points      <= cfg_points_d;
            cfg_settle      <= cfg_settle_d;
            cur_ftw         <= cur_ftw_d;
            index           <= index_d;
            disc_cnt        <= disc_cnt_d;
            acc_cnt         <= acc_cnt_d;
            sum             <= sum_d;
            wd_cnt          <= wd_cnt_d;
            ref_freq_tuning <= ref_freq_tuning_d;
            point_valid     <= point_valid_d;
            point_index     <= point_index_d;
            point_mag       <= point_mag_d;
            point_locked    <= point_locked_d;
            peak_ftw        <= peak_ftw_d;
            peak_mag        <= peak_mag_d;
            busy            <= busy_d;
            done            <= done_d;
            timeout_err     <= timeout_err_d;
        end
    end

    // Next-state and next-output logic; abort overrides every other event
    always_comb begin
        state_d           = state;
        cfg_step_d        = cfg_step;
        cfg_points_d      = cfg_points;
        cfg_settle_d      = cfg_settle;
        cur_ftw_d         = cur_ftw;
        index_d           = index;
        disc_cnt_d        = disc_cnt;
        acc_cnt_d         = acc_cnt;
        sum_d             = sum;
        wd_cnt_d          = wd_cnt;
        ref_freq_tuning_d = ref_freq_tuning;
        point_valid_d     = 1'b0;
        point_index_d     = point_index;
        point_mag_d       = point_mag;
        point_locked_d    = point_locked;
        peak_ftw_d        = peak_ftw;
        peak_mag_d        = peak_mag;
        done_d            = 1'b0;
        timeout_err_d     = timeout_err;

        if (abort && state != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && num_points != 12'd0) begin
                        cfg_step_d    = step_ftw;
                        cfg_points_d  = num_points;
                        cfg_settle_d  = settle_results;
                        cur_ftw_d     = start_ftw;
                        index_d       = 12'd0;
                        peak_ftw_d    = '0;
                        peak_mag_d    = '0;
                        timeout_err_d = 1'b0;
                        state_d       = S_PROGRAM;
                    end
                end
                S_PROGRAM: begin
                    ref_freq_tuning_d = cur_ftw;
                    disc_cnt_d        = cfg_settle;
                    acc_cnt_d         = '0;
                    sum_d             = '0;
                    wd_cnt_d          = '0;
                    state_d           = S_SETTLE;
                end
                S_SETTLE: begin
                    if (disc_cnt == 8'd0) begin
                        wd_cnt_d = '0;
                        state_d  = S_ACQUIRE;
                    end else if (lia_result_valid) begin
                        wd_cnt_d   = '0;
                        disc_cnt_d = disc_cnt - 8'd1;
                        if (disc_cnt == 8'd1) begin
                            state_d = S_ACQUIRE;
                        end
                    end else if (wd_expired_c) begin
                        timeout_err_d = 1'b1;
                        state_d       = S_IDLE;
                    end else begin
                        wd_cnt_d = wd_cnt + WD_WIDTH'(1);
                    end
                end
                S_ACQUIRE: begin
                    if (lia_result_valid) begin
                        wd_cnt_d  = '0;
                        sum_d     = sum + SUM_WIDTH'(lia_magnitude);
                        acc_cnt_d = acc_cnt + ACC_WIDTH'(1);
                        if (acc_cnt == ACC_WIDTH'(AVG_COUNT - 1)) begin
                            state_d = S_RECORD;
                        end
                    end else if (wd_expired_c) begin
                        timeout_err_d = 1'b1;
                        state_d       = S_IDLE;
                    end else begin
                        wd_cnt_d = wd_cnt + WD_WIDTH'(1);
                    end
                end
                S_RECORD: begin
                    point_valid_d  = 1'b1;
                    point_index_d  = index;
                    point_mag_d    = avg_c;
                    point_locked_d = lia_locked;
                    // Strict compare keeps the earliest of equal peaks
                    if (index == 12'd0 || avg_c > peak_mag) begin
                        peak_mag_d = avg_c;
                        peak_ftw_d = cur_ftw;
                    end
                    if (index == cfg_points - 12'd1) begin
                        state_d = S_DONE;
                    end else begin
                        cur_ftw_d = cur_ftw + cfg_step;
                        index_d   = index + 12'd1;
                        state_d   = S_PROGRAM;
                    end
                end
                S_DONE: begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_lockin_sweep_ctrl.sv
// Directed bench for lockin_sweep_ctrl: a point-level sweep model feeds a scoreboard
// that a single compare process checks against every point_valid and done pulse.
module tb_lockin_sweep_ctrl;

    localparam int unsigned TO    = 16;
    localparam int          AVG_N = 4;

    logic        clk, rst_n, start, abort;
    logic [31:0] start_ftw, step_ftw;
    logic [11:0] num_points;
    logic [7:0]  settle_results;
    logic [23:0] lia_magnitude;
    logic        lia_result_valid, lia_locked;
    logic [31:0] ref_freq_tuning, peak_ftw;
    logic        point_valid, point_locked, busy, done, timeout_err;
    logic [11:0] point_index;
    logic [23:0] point_mag, peak_mag;

    lockin_sweep_ctrl #(
        .FTW_WIDTH(32), .MAG_WIDTH(24), .AVG_LOG2(2), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .start_ftw(start_ftw), .step_ftw(step_ftw), .num_points(num_points),
        .settle_results(settle_results), .lia_magnitude(lia_magnitude),
        .lia_result_valid(lia_result_valid), .lia_locked(lia_locked),
        .ref_freq_tuning(ref_freq_tuning), .point_valid(point_valid),
        .point_index(point_index), .point_mag(point_mag), .point_locked(point_locked),
        .peak_ftw(peak_ftw), .peak_mag(peak_mag), .busy(busy), .done(done),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] idx;
        logic [23:0] mag;
        logic        locked;
        logic [31:0] pk_ftw;
        logic [23:0] pk_mag;
    } exp_pt_t;

    exp_pt_t     exp_q[$];
    exp_pt_t     cur_e;
    int          done_pending = 0;
    int          checks = 0;
    int          errors = 0;
    logic        prev_pv = 1'b0;
    logic [23:0] mag_tab[0:7][0:3];
    logic        lock_tab[0:7];
    logic [31:0] ftw_tab[0:7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Compare process: every point_valid and done pulse is matched against the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (point_valid) begin
                check("point_valid single cycle", 64'(prev_pv), 64'(0));
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected point_valid: index %0d mag %0d", point_index, point_mag);
                end else begin
                    cur_e = exp_q.pop_front();
                    check("point_index", 64'(point_index), 64'(cur_e.idx));
                    check("point_mag", 64'(point_mag), 64'(cur_e.mag));
                    check("point_locked", 64'(point_locked), 64'(cur_e.locked));
                    check("peak_mag", 64'(peak_mag), 64'(cur_e.pk_mag));
                    check("peak_ftw", 64'(peak_ftw), 64'(cur_e.pk_ftw));
                end
            end
            if (done) begin
                checks++;
                if (done_pending == 0) begin
                    errors++;
                    $display("FAIL unexpected done pulse: got 1 expected 0");
                end else begin
                    done_pending--;
                end
            end
            prev_pv = point_valid;
        end else begin
            prev_pv = 1'b0;
        end
    end

    task automatic set_mags(input int p, input int a, input int b, input int c, input int d,
                            input logic lk);
        mag_tab[p][0] = 24'(a);
        mag_tab[p][1] = 24'(b);
        mag_tab[p][2] = 24'(c);
        mag_tab[p][3] = 24'(d);
        lock_tab[p]   = lk;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic result(input logic [23:0] m);
        lia_result_valid = 1'b1;
        lia_magnitude    = m;
        @(negedge clk);
        lia_result_valid = 1'b0;
        lia_magnitude    = 24'h0;
        @(negedge clk);
    endtask

    task automatic wait_ref(input logic [31:0] ftw);
        int n = 0;
        while (ref_freq_tuning !== ftw && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ref_freq_tuning", 64'(ref_freq_tuning), 64'(ftw));
    endtask

    // Plays the lock-in for one point: settling results (poisoned so averaging them shows), then acquires
    task automatic feed_point(input logic [31:0] ftw, input logic [7:0] st, input int p,
                              input bit poke, input int n_acq);
        wait_ref(ftw);
        lia_locked = lock_tab[p];
        @(negedge clk);
        if (poke) begin
            start      = 1'b1;
            start_ftw  = 32'd9999;
            step_ftw   = 32'd1;
            num_points = 12'd1;
        end
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < int'(st); i++) result(24'hFF_FFFF);
        for (int i = 0; i < n_acq; i++) result(mag_tab[p][i]);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_pending != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("done pulse seen", 64'(done_pending), 64'(0));
        @(negedge clk);
        check("busy after done", 64'(busy), 64'(0));
        check("points drained", 64'(exp_q.size()), 64'(0));
    endtask

    // Sweep model: tuning words wrap mod 2^32, averages floor sum/4, peak strictly increasing
    task automatic run_sweep(input logic [31:0] sftw, input logic [31:0] stp,
                             input logic [11:0] np, input logic [7:0] st, input bit busy_poke);
        logic [31:0] f;
        logic [31:0] pk_f;
        logic [23:0] pk_m;
        logic [23:0] avg;
        exp_pt_t     e;
        int          sum;
        f    = sftw;
        pk_f = 32'd0;
        pk_m = 24'd0;
        for (int p = 0; p < int'(np); p++) begin
            sum = 0;
            for (int k = 0; k < AVG_N; k++) sum += int'(mag_tab[p][k]);
            avg = 24'(sum / AVG_N);
            if (p == 0 || avg > pk_m) begin
                pk_m = avg;
                pk_f = f;
            end
            ftw_tab[p] = f;
            e.idx    = 12'(p);
            e.mag    = avg;
            e.locked = lock_tab[p];
            e.pk_ftw = pk_f;
            e.pk_mag = pk_m;
            exp_q.push_back(e);
            f = f + stp;
        end
        done_pending++;
        start_ftw      = sftw;
        step_ftw       = stp;
        num_points     = np;
        settle_results = st;
        pulse_start();
        for (int p = 0; p < int'(np); p++) feed_point(ftw_tab[p], st, p, busy_poke && p == 1, AVG_N);
        wait_done();
    endtask

    initial begin
        #100000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int          n;
        exp_pt_t     e;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        start_ftw = '0; step_ftw = '0; num_points = '0; settle_results = '0;
        lia_magnitude = '0; lia_result_valid = 1'b0; lia_locked = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outputs", 64'({ref_freq_tuning, point_valid, point_index, busy, done, timeout_err}), 64'(0));
        check("reset mags", 64'({point_mag, peak_mag, point_locked}), 64'(0));
        check("reset peak_ftw", 64'(peak_ftw), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Basic three-point sweep
        set_mags(0, 10, 10, 10, 10, 1'b1);
        set_mags(1, 50, 50, 50, 50, 1'b0);
        set_mags(2, 30, 30, 30, 30, 1'b1);
        run_sweep(32'd1000, 32'd100, 12'd3, 8'd2, 1'b0);
        check("sweep1 peak_ftw", 64'(peak_ftw), 64'(1100));
        check("sweep1 peak_mag", 64'(peak_mag), 64'(50));
        check("sweep1 last ftw held", 64'(ref_freq_tuning), 64'(1200));

        // Averaging with truncation, zero settle
        set_mags(0, 4, 5, 6, 8, 1'b1);
        run_sweep(32'd5000, 32'd7, 12'd1, 8'd0, 1'b0);
        check("avg point_mag", 64'(point_mag), 64'(5));

        // Tuning-word wraparound
        set_mags(0, 7, 7, 7, 7, 1'b0);
        set_mags(1, 7, 7, 7, 7, 1'b1);
        run_sweep(32'hFFFF_FF00, 32'h200, 12'd2, 8'd1, 1'b0);
        check("wrap second ftw", 64'(ref_freq_tuning), 64'(32'h0000_0100));
        check("wrap tie peak_ftw", 64'(peak_ftw), 64'(32'hFFFF_FF00));

        // Equal magnitudes, plus a start with new config while busy
        for (int p = 0; p < 4; p++) set_mags(p, 9, 9, 9, 9, 1'b1);
        run_sweep(32'd300, 32'd20, 12'd4, 8'd1, 1'b1);
        check("equal peak_ftw", 64'(peak_ftw), 64'(300));
        check("equal peak_mag", 64'(peak_mag), 64'(9));

        // Abort during point 1 acquisition
        set_mags(0, 40, 40, 40, 40, 1'b1);
        set_mags(1, 60, 60, 60, 60, 1'b1);
        e.idx = 12'd0; e.mag = 24'd40; e.locked = 1'b1; e.pk_ftw = 32'd2000; e.pk_mag = 24'd40;
        exp_q.push_back(e);
        start_ftw = 32'd2000; step_ftw = 32'd50; num_points = 12'd3; settle_results = 8'd1;
        pulse_start();
        feed_point(32'd2000, 8'd1, 0, 1'b0, 4);
        feed_point(32'd2050, 8'd1, 1, 1'b0, 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort busy next cycle", 64'(busy), 64'(0));
        repeat (10) @(negedge clk);
        check("abort peak_mag", 64'(peak_mag), 64'(40));
        check("abort peak_ftw", 64'(peak_ftw), 64'(2000));
        check("abort points drained", 64'(exp_q.size()), 64'(0));

        // Watchdog: no results after programming
        start_ftw = 32'd7000; step_ftw = 32'd1; num_points = 12'd2; settle_results = 8'd2;
        pulse_start();
        wait_ref(32'd7000);
        n = 0;
        while (timeout_err !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("timeout latency", 64'(n), 64'(16));
        check("timeout busy", 64'(busy), 64'(0));
        repeat (5) @(negedge clk);
        check("timeout sticky", 64'(timeout_err), 64'(1));

        // Next start clears the error
        set_mags(0, 12, 12, 12, 12, 1'b0);
        start_ftw = 32'd8000; step_ftw = 32'd1; num_points = 12'd1; settle_results = 8'd0;
        pulse_start();
        check("timeout cleared by start", 64'(timeout_err), 64'(0));
        done_pending++;
        e.idx = 12'd0; e.mag = 24'd12; e.locked = 1'b0; e.pk_ftw = 32'd8000; e.pk_mag = 24'd12;
        exp_q.push_back(e);
        feed_point(32'd8000, 8'd0, 0, 1'b0, 4);
        wait_done();

        // num_points == 0 is ignored
        num_points = 12'd0;
        pulse_start();
        @(negedge clk);
        check("zero points busy", 64'(busy), 64'(0));

        // Reset mid-sweep
        set_mags(0, 3, 3, 3, 3, 1'b1);
        start_ftw = 32'd9000; num_points = 12'd2; settle_results = 8'd1;
        pulse_start();
        feed_point(32'd9000, 8'd1, 0, 1'b0, 2);
        rst_n = 1'b0;
        #1;
        check("async reset outputs", 64'({ref_freq_tuning, busy, done, timeout_err, point_valid}), 64'(0));
        check("async reset peak", 64'({peak_mag, point_mag}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post-reset idle", 64'(busy), 64'(0));
        check("no stray done", 64'(done_pending), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
